// File: rtl/pdu_io_pkg.sv
// Shared channel map and debounce state encoding for the PDU input conditioning block.
package pdu_io_pkg;

  localparam int CH_IN0   = 0;
  localparam int CH_IN1   = 1;
  localparam int CH_IN2   = 2;
  localparam int CH_IN3   = 3;
  localparam int CH_IN4   = 4;
  localparam int CH_VALID = 5;
  localparam int CH_STEP  = 6;
  localparam int CH_RUN   = 7;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stable-count FSM, registered level and pulses.
// Optional auto-repeat of the rise pulse is compiled in with DEBOUNCE_REPEAT_EN.
module debounce_ch
  import pdu_io_pkg::*;
#(
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_W      = 20
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter bit REPEAT_ON  = 1'b0,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1_r, sync2_r;
  db_state_t        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             level_r, level_s;
  logic             rise_r, rise_s;
  logic             fall_r, fall_s;
  logic             change_r;
  logic             fsm_rise_s;
  logic             rep_fire_s;

  // Next-state and output decode of the stable-count FSM.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    level_s    = level_r;
    fsm_rise_s = 1'b0;
    fall_s     = 1'b0;
    case (state_r)
      S_LOW: begin
        if (sync2_r) begin
          state_s = S_RISE_WAIT;
          cnt_s   = CNT_W'(1);
        end else begin
          cnt_s   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!sync2_r) begin
          state_s = S_LOW;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s    = S_HIGH;
          cnt_s      = '0;
          level_s    = 1'b1;
          fsm_rise_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync2_r) begin
          state_s = S_FALL_WAIT;
          cnt_s   = CNT_W'(1);
        end else begin
          cnt_s   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (sync2_r) begin
          state_s = S_HIGH;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = S_LOW;
          cnt_s   = '0;
          level_s = 1'b0;
          fall_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_LOW;
        cnt_s   = '0;
        level_s = 1'b0;
      end
    endcase
    rise_s = fsm_rise_s | rep_fire_s;
  end

`ifdef DEBOUNCE_REPEAT_EN
  if (REPEAT_ON) begin : g_repeat
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
    logic             rep_armed_r, rep_armed_s;

    // Repeat timer: first period is the initial delay, later ones the repeat period.
    always_comb begin
      rep_cnt_s   = '0;
      rep_armed_s = 1'b0;
      rep_fire_s  = 1'b0;
      if (state_r == S_HIGH && state_s == S_HIGH) begin
        if (rep_cnt_r == (rep_armed_r ? REP_W'(REPEAT_PER - 1) : REP_W'(REPEAT_DLY - 1))) begin
          rep_fire_s  = 1'b1;
          rep_armed_s = 1'b1;
        end else begin
          rep_cnt_s   = rep_cnt_r + REP_W'(1);
          rep_armed_s = rep_armed_r;
        end
      end else begin
        rep_cnt_s   = '0;
        rep_armed_s = 1'b0;
      end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt_r   <= '0;
        rep_armed_r <= 1'b0;
      end else begin
        rep_cnt_r   <= rep_cnt_s;
        rep_armed_r <= rep_armed_s;
      end
    end
  end else begin : g_no_repeat
    assign rep_fire_s = 1'b0;
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      state_r  <= S_LOW;
      cnt_r    <= '0;
      level_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      change_r <= 1'b0;
    end else begin
      sync1_r  <= raw;
      sync2_r  <= sync1_r;
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      level_r  <= level_s;
      rise_r   <= rise_s;
      fall_r   <= fall_s;
      change_r <= rise_s | fall_s;
    end
  end

  assign level  = level_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign change = change_r;

endmodule

// File: rtl/pdu_input_debounce.sv
// Debounces the PDU's raw switches/buttons: [4:0]=in, 5=valid, 6=step, 7=run.
// Define DEBOUNCE_REPEAT_EN to enable auto-repeat rise pulses on REPEAT_MASK channels.
module pdu_input_debounce
  import pdu_io_pkg::*;
#(
  parameter int              N_CH        = 8,
  parameter int              STABLE_CNT  = 1000000,
  parameter int              CNT_W       = 20,
  parameter logic [N_CH-1:0] REPEAT_MASK = N_CH'(1) << CH_STEP,
  parameter int              REPEAT_DLY  = 50000000,
  parameter int              REPEAT_PER  = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall,
  output logic [N_CH-1:0] db_change
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_ON  (REPEAT_MASK[i]),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_in[i]),
      .level  (db_level[i]),
      .rise   (db_rise[i]),
      .fall   (db_fall[i]),
      .change (db_change[i])
    );
  end

`ifndef DEBOUNCE_REPEAT_EN
  // Repeat parameters stay on the interface but have no effect in this build.
  if (REPEAT_MASK == '0 && REPEAT_DLY < 0 && REPEAT_PER < 0) begin : g_repeat_unused
  end
`endif

endmodule

// File: tb/tb_pdu_input_debounce.sv
// Scoreboard bench for pdu_input_debounce with STABLE_CNT=4, REPEAT_DLY=10, REPEAT_PER=3.
module tb_pdu_input_debounce;

  localparam bit REP_ON =
`ifdef DEBOUNCE_REPEAT_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] raw_in = 8'h00;
  logic [7:0] db_level, db_rise, db_fall, db_change;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pdu_input_debounce #(
    .N_CH(8), .STABLE_CNT(4), .CNT_W(3), .REPEAT_MASK(8'h40),
    .REPEAT_DLY(10), .REPEAT_PER(3)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall), .db_change(db_change)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [7:0] lv, input logic [7:0] rs, input logic [7:0] fl, input int n);
    exp_t e;
    e.level = lv; e.rise = rs; e.fall = fl;
    repeat (n) exp_q.push_back(e);
  endtask

  // Leaves time at #1 after an edge with rst released; the next edge is edge 1.
  task automatic do_reset(input logic [7:0] raw);
    raw_in = raw;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    exp_t e;
    raw_in = 8'hFF;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({db_level, db_rise, db_fall, db_change} !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected 00000000", {db_level, db_rise, db_fall, db_change});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({db_level, db_rise, db_fall, db_change} !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h expected 00000000", {db_level, db_rise, db_fall, db_change});
    end
    push_exp(8'h00, 8'h00, 8'h00, 5);
    push_exp(8'hFF, 8'hFF, 8'h00, 1);
    push_exp(8'hFF, 8'h00, 8'h00, 2);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL reset_latency edge %0d: level/rise/fall/change=%h/%h/%h/%h expected %h/%h/%h/%h",
                 c, db_level, db_rise, db_fall, db_change, e.level, e.rise, e.fall, e.rise | e.fall);
      end
    end
  endtask

  task automatic test_single_rise;
    exp_t e;
    do_reset(8'h00);
    raw_in = 8'h01;
    push_exp(8'h00, 8'h00, 8'h00, 5);
    push_exp(8'h01, 8'h01, 8'h00, 1);
    push_exp(8'h01, 8'h00, 8'h00, 4);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL single_rise edge %0d: level/rise/fall/change=%h/%h/%h/%h expected %h/%h/%h/%h",
                 c, db_level, db_rise, db_fall, db_change, e.level, e.rise, e.fall, e.rise | e.fall);
      end
    end
  endtask

  task automatic test_glitch;
    exp_t e;
    do_reset(8'h00);
    push_exp(8'h00, 8'h00, 8'h00, 16);
    for (int c = 1; c <= 16; c++) begin
      raw_in[5] = (c <= 8) && ((((c - 1) / 2) % 2) == 0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL glitch edge %0d: level/rise/fall/change=%h/%h/%h/%h expected all zero",
                 c, db_level, db_rise, db_fall, db_change);
      end
    end
  endtask

  task automatic test_repeat;
    exp_t e;
    logic [7:0] lv, rs, fl;
    do_reset(8'h00);
    for (int c = 1; c <= 28; c++) begin
      lv = (c >= 6 && c <= 25) ? 8'h40 : 8'h00;
      rs = (c == 6 || (REP_ON && (c == 16 || c == 19 || c == 22))) ? 8'h40 : 8'h00;
      fl = (c == 26) ? 8'h40 : 8'h00;
      push_exp(lv, rs, fl, 1);
    end
    for (int c = 1; c <= 28; c++) begin
      raw_in[6] = (c <= 20);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL step_repeat edge %0d: level/rise/fall/change=%h/%h/%h/%h expected %h/%h/%h/%h",
                 c, db_level, db_rise, db_fall, db_change, e.level, e.rise, e.fall, e.rise | e.fall);
      end
    end
  endtask

  task automatic test_reset_mid_count;
    exp_t e;
    do_reset(8'h00);
    raw_in = 8'h80;
    push_exp(8'h00, 8'h00, 8'h00, 4);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL midcount_pre edge %0d: outputs=%h expected 00000000",
                 c, {db_level, db_rise, db_fall, db_change});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== 32'h0) begin
        errors++;
        $display("FAIL midcount_in_reset step %0d: outputs=%h expected 00000000",
                 c, {db_level, db_rise, db_fall, db_change});
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    push_exp(8'h00, 8'h00, 8'h00, 5);
    push_exp(8'h80, 8'h80, 8'h00, 1);
    push_exp(8'h80, 8'h00, 8'h00, 2);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL midcount_post edge %0d: level/rise/fall/change=%h/%h/%h/%h expected %h/%h/%h/%h",
                 c, db_level, db_rise, db_fall, db_change, e.level, e.rise, e.fall, e.rise | e.fall);
      end
    end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    do_reset(8'h00);
    push_exp(8'h00, 8'h00, 8'h00, 5);
    push_exp(8'h81, 8'h81, 8'h00, 1);
    push_exp(8'h81, 8'h00, 8'h00, 7);
    push_exp(8'h00, 8'h00, 8'h81, 1);
    push_exp(8'h00, 8'h00, 8'h00, 2);
    for (int c = 1; exp_q.size() > 0; c++) begin
      raw_in = (c <= 8) ? 8'h81 : 8'h00;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({db_level, db_rise, db_fall, db_change} !== {e.level, e.rise, e.fall, e.rise | e.fall}) begin
        errors++;
        $display("FAIL simultaneous edge %0d: level/rise/fall/change=%h/%h/%h/%h expected %h/%h/%h/%h",
                 c, db_level, db_rise, db_fall, db_change, e.level, e.rise, e.fall, e.rise | e.fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_repeat();
    test_reset_mid_count();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
